// File: rtl/ship_motion_ctrl.sv
// Ship motion controller: turns synchronized accelerometer tilt samples into
// a per-frame velocity and a clamped on-screen ship position.
module ship_motion_ctrl #(
    parameter int CORDW        = 16,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int SHIP_W       = 34,
    parameter int SHIP_H       = 36,
    parameter int START_X      = 300,
    parameter int START_Y      = 240,
    parameter int DEADZONE     = 64,
    parameter int SHIFT        = 6,
    parameter int MAX_SPEED    = 4,
    parameter int STALE_FRAMES = 8
) (
    input  logic             clk_pix,
    input  logic             reset_n,
    input  logic             en,
    input  logic             frame,
    input  logic             data_update,
    input  logic [15:0]      data_x,
    input  logic [15:0]      data_y,
    output logic [CORDW-1:0] ship_x,
    output logic [CORDW-1:0] ship_y,
    output logic [7:0]       vel_x,
    output logic [7:0]       vel_y,
    output logic [3:0]       at_edge,
    output logic             sample_valid
);

    localparam int CW = $clog2(STALE_FRAMES + 1);
    localparam logic [15:0] DZ   = 16'(DEADZONE);
    localparam logic [15:0] MAXS = 16'(MAX_SPEED);
    localparam logic signed [CORDW:0] X_MAX = (CORDW+1)'(H_RES - SHIP_W);
    localparam logic signed [CORDW:0] Y_MAX = (CORDW+1)'(V_RES - SHIP_H);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_STALE} state_t;

    state_t           r_state, w_state_next;
    logic             r_sync1, r_sync2, r_sync3, r_new;
    logic [15:0]      r_dx, r_dy;
    logic [7:0]       r_vel_x, r_vel_y, w_vel_x_next, w_vel_y_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             w_step, w_rise;
    logic [CORDW-1:0] r_ship_x, r_ship_y, w_nx, w_ny;
    logic [3:0]       r_at_edge, w_edge_next;
    logic signed [CORDW:0] w_sum_x, w_sum_y;

    // Magnitude-to-speed map; neg selects the sign of the returned velocity.
    function automatic logic [7:0] speed_of(input logic [15:0] d, input logic neg);
        logic [15:0] m;
        logic [15:0] e;
        logic [7:0]  s;
        if (d == 16'h8000)  m = 16'h7FFF;
        else if (d[15])     m = ~d + 16'd1;
        else                m = d;
        if (m <= DZ) begin
            s = 8'd0;
        end else begin
            e = (m - DZ) >> SHIFT;
            s = (e > MAXS) ? MAXS[7:0] : e[7:0];
        end
        return neg ? (~s + 8'd1) : s;
    endfunction

    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_new   <= 1'b0;
            r_dx    <= 16'd0;
            r_dy    <= 16'd0;
        end else begin
            r_sync1 <= data_update;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_new   <= w_rise;
            if (w_rise) begin
                r_dx <= data_x;
                r_dy <= data_y;
            end
        end
    end

    // A fresh sample overrides whatever the frame logic decided this cycle;
    // the step itself still uses the velocity currently in the registers.
    always_comb begin
        w_state_next = r_state;
        w_vel_x_next = r_vel_x;
        w_vel_y_next = r_vel_y;
        w_cnt_next   = r_cnt;
        w_step       = 1'b0;
        case (r_state)
            S_TRACK: begin
                if (frame && en) begin
                    w_step     = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == CW'(STALE_FRAMES - 1)) begin
                        w_state_next = S_STALE;
                        w_vel_x_next = 8'd0;
                        w_vel_y_next = 8'd0;
                    end
                end
            end
            default: ;
        endcase
        if (r_new) begin
            w_state_next = S_TRACK;
            w_vel_x_next = speed_of(r_dx, ~r_dx[15]);
            w_vel_y_next = speed_of(r_dy, r_dy[15]);
            w_cnt_next   = '0;
        end
    end

    assign w_sum_x = $signed({r_ship_x[CORDW-1], r_ship_x}) + $signed({{(CORDW-7){r_vel_x[7]}}, r_vel_x});
    assign w_sum_y = $signed({r_ship_y[CORDW-1], r_ship_y}) + $signed({{(CORDW-7){r_vel_y[7]}}, r_vel_y});

    always_comb begin
        w_nx = w_sum_x[CORDW-1:0];
        w_ny = w_sum_y[CORDW-1:0];
        if (w_sum_x < 0)          w_nx = '0;
        else if (w_sum_x > X_MAX) w_nx = X_MAX[CORDW-1:0];
        if (w_sum_y < 0)          w_ny = '0;
        else if (w_sum_y > Y_MAX) w_ny = Y_MAX[CORDW-1:0];
        w_edge_next = {w_ny == Y_MAX[CORDW-1:0], w_ny == '0,
                       w_nx == X_MAX[CORDW-1:0], w_nx == '0};
    end

    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_vel_x   <= 8'd0;
            r_vel_y   <= 8'd0;
            r_cnt     <= '0;
            r_ship_x  <= CORDW'(START_X);
            r_ship_y  <= CORDW'(START_Y);
            r_at_edge <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_vel_x <= w_vel_x_next;
            r_vel_y <= w_vel_y_next;
            r_cnt   <= w_cnt_next;
            if (w_step) begin
                r_ship_x  <= w_nx;
                r_ship_y  <= w_ny;
                r_at_edge <= w_edge_next;
            end
        end
    end

    assign ship_x       = r_ship_x;
    assign ship_y       = r_ship_y;
    assign vel_x        = r_vel_x;
    assign vel_y        = r_vel_y;
    assign at_edge      = r_at_edge;
    assign sample_valid = (r_state == S_TRACK);

endmodule
